clk_div_sched: RTL
==================

# clk_div_sched

Runtime-programmable integer clock divider controller. It generates a 50%-duty divided clock, even or odd ratio, from `clk`. It accepts divisor changes through a valid/ready handshake and applies them only at a period boundary, so every output period is whole. A start/stop enable parks the output low without runt pulses. It sits between the system-control register block and the downstream logic clocked from `clk_out`.

## Interface
- `W`, 8: divisor width in bits.
- `DEF_DIV`, 4: divisor loaded at reset. Must be a legal divisor.
- `clk` input 1: system clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `en` input 1: run request. High runs the divider, low stops it at the next period boundary.
- `cfg_valid` input 1: a new divisor is offered.
- `cfg_div` input W: the offered divisor.
- `cfg_ready` output 1: the block can accept a divisor. High when no change is pending.
- `cfg_err` output 1: one-cycle pulse when an offered divisor is rejected.
- `cur_div` output W: the divisor currently in effect.
- `running` output 1: high in RUN and DRAIN.
- `period_start` output 1: one-cycle pulse on the `clk` cycle where `cnt`==0 while running.
- `clk_out` output 1: the divided clock.

## Operation
- **Legal divisors:** D in [2, 2^W−1]. D=0 and D=1 are illegal.
- **Illegal divisor handshake:** the handshake still completes. `cfg_err` pulses the following cycle and nothing is stored.
- **Counter:** `cnt` (W bits) counts 0..D−1 on `posedge clk` and wraps to 0 after D−1. A period boundary is the edge where `cnt`==D−1 advances.
- **Waveform (`pos_q` and `neg_q`):**
  - `pos_q` is a posedge register, high while `cnt` < floor(D/2).
  - `neg_q` is `pos_q` resampled on `negedge clk`.
  - For even D, `clk_out` = `pos_q`. For odd D, `clk_out` = `pos_q` | `neg_q`.
  - Result: high for D/2 `clk` periods, low for D/2 periods. For D=3 that is high 1.5, low 1.5.
- **State machine:**
  - IDLE: `cnt`=0, `pos_q`=0. If `en`=1 go to RUN. On entry, `cnt`=0 and `pos_q`=1 at the same edge.
  - RUN: at a boundary, if `en`=0 go to DRAIN. Otherwise wrap and continue.
  - DRAIN: in practice entered at the boundary. `pos_q` stays 0 and the block goes to IDLE on the next edge. `en` reasserted in DRAIN goes straight back to RUN with no extra idle cycle.
- **Pending register:**
  - `cfg_valid`&&`cfg_ready` with a legal D loads `pend_div` and sets `pend_vld`. `cfg_ready` falls on the next cycle.
  - In RUN, the pending divisor is applied at the first boundary strictly after capture. Capture on the boundary cycle itself waits for the next boundary.
  - In IDLE, it is applied on the next edge.
  - Applying copies `pend_div` to `cur_div`, clears `pend_vld`, and raises `cfg_ready`.
- **Simultaneous events:**
  - Boundary with `en`=0 and `pend_vld`: the divisor is applied and DRAIN is entered.
  - `cfg_valid` while `cfg_ready`=0: ignored, with no error.
- **Reset mid-operation:** `clk_out` falls asynchronously, the pending change is discarded, and `cur_div` returns to DEF_DIV.

## Timing
- **Reset values:**
  - `clk_out`=0, `cfg_ready`=1, `cfg_err`=0, `running`=0, `period_start`=0.
  - `cur_div`=DEF_DIV, `cnt`=0, state IDLE.
- **Start latency:** `en` sampled high at edge k makes `clk_out` rise at edge k (clock-to-q). `period_start` is high in the cycle after edge k.
- **Stop:** the current period always completes, and `clk_out` is low from the end of that period.
- **Config latency:**
  - In IDLE, a divisor accepted at edge k is in effect, and `cfg_ready` is back high, from edge k+1.
  - In RUN, the new divisor takes effect at the next boundary, worst case D_old+1 cycles.
- **Outputs:** all registered. The only combinational path is the final OR on `clk_out` for odd D.

## Configuration
- `CLK_DIV_ODD_EN` defined: odd divisors are legal and the `negedge` `neg_q` flop is built.
- Macro undefined:
  - odd D is illegal and gets the `cfg_err` pulse;
  - `neg_q` is removed and `clk_out` = `pos_q`;
  - DEF_DIV must be even.

## Structure
- The shared package `clk_div_pkg` holds:
  - the state enum `{IDLE, RUN, DRAIN}`;
  - the constant `MIN_DIV`=2;
  - the function `div_legal(d)`, which honours the macro.
- One natural sub-module is `clk_div_core`: `cnt`, `pos_q`, `neg_q`, and the output OR, taking the divisor and a run signal.
- `clk_div_sched` owns the FSM, the handshake and the pending register.

## Test plan
- Reset, `en`=1, DEF_DIV=4 -> `clk_out` runs 2 high / 2 low, and `period_start` pulses every 4 cycles.
- In IDLE, offer D=3, then `en`=1 -> `cur_div`=3 next cycle, and `clk_out` is 1.5 high / 1.5 low with a 3-cycle period.
- In RUN at D=4, offer D=6 at `cnt`=1 -> the 4-period completes, then 6-periods follow (3 high / 3 low). `cfg_ready` stays low until the switch.
- Offer D=1, then D=0 -> one `cfg_err` pulse for each, and `cur_div` is unchanged. With the macro undefined, D=5 also pulses `cfg_err`.
- `en` dropped at `cnt`=0 of a D=6 period -> the full 6-cycle period completes, `clk_out` stays low, and the block returns to IDLE with `running`=0.
- Assert `rst_n`=0 mid-high-phase with a change pending -> `clk_out`=0 immediately. After release, `cur_div`=DEF_DIV and `cfg_ready`=1.

Source files
------------

// File: rtl/clk_div_pkg.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_pkg
// Purpose  : Shared FSM states, minimum divisor and divisor legality check.
//            Odd divisors are legal only when CLK_DIV_ODD_EN is defined.
// Revision : 1.0
// ============================================================================
package clk_div_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int unsigned MIN_DIV = 2;

  function automatic logic div_legal(input logic [31:0] d);
`ifdef CLK_DIV_ODD_EN
    return (d >= MIN_DIV);
`else
    return (d >= MIN_DIV) && !d[0];
`endif
  endfunction

endpackage
`default_nettype wire

// File: rtl/clk_div_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_sched_if
// Purpose  : Run request, divisor handshake and divided-clock status bundle.
// Revision : 1.0
// ============================================================================
interface clk_div_sched_if #(
  parameter int W = 8
);
  logic         en;
  logic         cfg_valid;
  logic [W-1:0] cfg_div;
  logic         cfg_ready;
  logic         cfg_err;
  logic [W-1:0] cur_div;
  logic         running;
  logic         period_start;
  logic         clk_out;

  modport master (
    output en, cfg_valid, cfg_div,
    input  cfg_ready, cfg_err, cur_div, running, period_start, clk_out
  );

  modport slave (
    input  en, cfg_valid, cfg_div,
    output cfg_ready, cfg_err, cur_div, running, period_start, clk_out
  );
endinterface
`default_nettype wire

// File: rtl/clk_div_core.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_core
// Purpose  : Period counter and 50%-duty waveform; CLK_DIV_ODD_EN adds the
//            negedge flop that stretches odd-ratio high phases by half a cycle.
// Revision : 1.0
// ============================================================================
module clk_div_core #(
  parameter int W = 8
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  input  wire logic [W-1:0] div,
  input  wire logic         active,
  input  wire logic         go,
  output logic              boundary,
  output logic              clk_out
);
  logic [W-1:0] r_cnt;
  logic         r_pos_q;
  logic [W-1:0] w_cnt_inc;
  logic [W-1:0] w_half;

  assign w_half    = div >> 1;
  assign w_cnt_inc = r_cnt + W'(1);
  assign boundary  = active && (r_cnt == div - W'(1));

  // Entering RUN or wrapping both restart the period with the high phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_pos_q <= 1'b0;
    end else if (!go) begin
      r_cnt   <= '0;
      r_pos_q <= 1'b0;
    end else if (!active || boundary) begin
      r_cnt   <= '0;
      r_pos_q <= 1'b1;
    end else begin
      r_cnt   <= w_cnt_inc;
      r_pos_q <= (w_cnt_inc < w_half);
    end
  end

`ifdef CLK_DIV_ODD_EN
  logic r_neg_q;

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) r_neg_q <= 1'b0;
    else        r_neg_q <= r_pos_q;
  end

  assign clk_out = div[0] ? (r_pos_q | r_neg_q) : r_pos_q;
`else
  assign clk_out = r_pos_q;
`endif

endmodule
`default_nettype wire

// File: rtl/clk_div_sched.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_sched
// Purpose  : Run/stop FSM and divisor handshake around clk_div_core; divisor
//            changes land only on period boundaries. Odd ratios: CLK_DIV_ODD_EN.
// Revision : 1.0
// ============================================================================
module clk_div_sched
  import clk_div_pkg::*;
#(
  parameter int W       = 8,
  parameter int DEF_DIV = 4
) (
  input wire logic        clk,
  input wire logic        rst_n,
  clk_div_sched_if.slave  bus
);
  state_t       r_state;
  state_t       w_state_nxt;
  logic [W-1:0] r_cur_div;
  logic [W-1:0] r_pend_div;
  logic         r_pend_vld;
  logic         r_cfg_ready;
  logic         r_cfg_err;
  logic         r_running;
  logic         r_period_start;

  logic         w_active;
  logic         w_boundary;
  logic         w_accept;
  logic         w_legal;
  logic         w_apply;
  logic         w_go;
  logic         w_ps_nxt;

  assign w_active = (r_state == RUN);
  assign w_accept = bus.cfg_valid && r_cfg_ready;
  assign w_legal  = div_legal(32'(bus.cfg_div));
  // Outside RUN there is no period in flight, so a pending divisor lands at once.
  assign w_apply  = r_pend_vld && (!w_active || w_boundary);
  assign w_go     = (w_state_nxt == RUN);
  assign w_ps_nxt = w_go && (!w_active || w_boundary);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (bus.en) w_state_nxt = RUN;
      RUN:     if (w_boundary && !bus.en) w_state_nxt = DRAIN;
      DRAIN:   w_state_nxt = bus.en ? RUN : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cur_div      <= W'(DEF_DIV);
      r_pend_div     <= '0;
      r_pend_vld     <= 1'b0;
      r_cfg_ready    <= 1'b1;
      r_cfg_err      <= 1'b0;
      r_running      <= 1'b0;
      r_period_start <= 1'b0;
    end else begin
      r_cfg_err      <= w_accept && !w_legal;
      r_running      <= (w_state_nxt != IDLE);
      r_period_start <= w_ps_nxt;
      // Accept needs ready (nothing pending) and apply needs pending: exclusive.
      if (w_apply) begin
        r_cur_div   <= r_pend_div;
        r_pend_vld  <= 1'b0;
        r_cfg_ready <= 1'b1;
      end else if (w_accept && w_legal) begin
        r_pend_div  <= bus.cfg_div;
        r_pend_vld  <= 1'b1;
        r_cfg_ready <= 1'b0;
      end
    end
  end

  clk_div_core #(
    .W (W)
  ) u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .div      (r_cur_div),
    .active   (w_active),
    .go       (w_go),
    .boundary (w_boundary),
    .clk_out  (bus.clk_out)
  );

  assign bus.cfg_ready    = r_cfg_ready;
  assign bus.cfg_err      = r_cfg_err;
  assign bus.cur_div      = r_cur_div;
  assign bus.running      = r_running;
  assign bus.period_start = r_period_start;

endmodule
`default_nettype wire
